// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for the frame analyzer slice.
package frame_pkg;
  localparam int FRAME_WIDTH  = 96;
  localparam int FRAME_HEIGHT = 96;
  localparam int NPIX         = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int ADDR_W       = 15;
  localparam int COORD_W      = 7;
  localparam int COUNT_W      = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/frame_analyzer_scan_counter.sv
// Raster scan generator: x runs fastest, y steps on x wrap, address tracks y*WIDTH+x.
module scan_counter
  import frame_pkg::*;
#(
  parameter int WIDTH  = FRAME_WIDTH,
  parameter int HEIGHT = FRAME_HEIGHT,
  parameter int AW     = ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [AW-1:0]      addr,
  output logic               last
);
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               x_end;

  assign x_end = (x_q == COORD_W'(WIDTH - 1));
  assign last  = x_end && (y_q == COORD_W'(HEIGHT - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (en) begin
      // Wrapping to zero after the last pixel keeps the address at 0 once the scan ends.
      if (last) begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end else if (x_end) begin
        x_d    = '0;
        y_d    = y_q + COORD_W'(1);
        addr_d = addr_q + AW'(1);
      end else begin
        x_d    = x_q + COORD_W'(1);
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;
endmodule

// File: rtl/frame_analyzer.sv
// Scans the frame buffer once per start, counting pixels at/above a threshold
// and tracking their bounding box.
module frame_analyzer
  import frame_pkg::*;
#(
  parameter int FRAME_WIDTH  = frame_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = frame_pkg::FRAME_HEIGHT,
  parameter int ADDR_W       = frame_pkg::ADDR_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [7:0]         i_Threshold,
  output logic [ADDR_W-1:0]  o_RAM_Read_Adress,
  input  logic [7:0]         i_RAM_Data,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Found,
  output logic [COUNT_W-1:0] o_Count,
  output logic [COORD_W-1:0] o_Min_X,
  output logic [COORD_W-1:0] o_Max_X,
  output logic [COORD_W-1:0] o_Min_Y,
  output logic [COORD_W-1:0] o_Max_Y
);
  state_e             state_q, state_d;
  logic [7:0]         thr_q, thr_d;
  logic               vld_q, vld_d;
  logic [COORD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic [COORD_W-1:0] mnx_q, mnx_d, mxx_q, mxx_d, mny_q, mny_d, mxy_q, mxy_d;
  logic [COORD_W-1:0] omnx_q, omnx_d, omxx_q, omxx_d, omny_q, omny_d, omxy_q, omxy_d;
  logic               busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic               scan_en, scan_clr, scan_last, match;
  logic [COORD_W-1:0] scan_x, scan_y;

  assign scan_en = (state_q == ST_READ);
  // Data returns one cycle after its address, so the coordinates are delayed to match.
  assign match   = vld_q && (i_RAM_Data >= thr_q);

  scan_counter #(
    .WIDTH (FRAME_WIDTH),
    .HEIGHT(FRAME_HEIGHT),
    .AW    (ADDR_W)
  ) u_scan (
    .clk (i_Clk),
    .rst (i_Rst),
    .en  (scan_en),
    .clr (scan_clr),
    .x   (scan_x),
    .y   (scan_y),
    .addr(o_RAM_Read_Adress),
    .last(scan_last)
  );

  always_comb begin
    state_d  = state_q;
    thr_d    = thr_q;
    vld_d    = (state_q == ST_READ);
    px_x_d   = scan_x;
    px_y_d   = scan_y;
    cnt_d    = cnt_q;
    mnx_d    = mnx_q;
    mxx_d    = mxx_q;
    mny_d    = mny_q;
    mxy_d    = mxy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    ocnt_d   = ocnt_q;
    omnx_d   = omnx_q;
    omxx_d   = omxx_q;
    omny_d   = omny_q;
    omxy_d   = omxy_q;
    scan_clr = 1'b0;

    if (match) begin
      cnt_d = cnt_q + COUNT_W'(1);
      if (px_x_q < mnx_q) mnx_d = px_x_q;
      if (px_x_q > mxx_q) mxx_d = px_x_q;
      if (px_y_q < mny_q) mny_d = px_y_q;
      if (px_y_q > mxy_q) mxy_d = px_y_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d  = ST_READ;
          thr_d    = i_Threshold;
          cnt_d    = '0;
          mnx_d    = '1;
          mxx_d    = '0;
          mny_d    = '1;
          mxy_d    = '0;
          scan_clr = 1'b1;
        end
      end
      ST_READ:  if (scan_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        found_d = (cnt_q != '0);
        ocnt_d  = cnt_q;
        omnx_d  = found_d ? mnx_q : '0;
        omxx_d  = found_d ? mxx_q : '0;
        omny_d  = found_d ? mny_q : '0;
        omxy_d  = found_d ? mxy_q : '0;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      thr_q   <= '0;
      vld_q   <= 1'b0;
      px_x_q  <= '0;
      px_y_q  <= '0;
      cnt_q   <= '0;
      mnx_q   <= '1;
      mxx_q   <= '0;
      mny_q   <= '1;
      mxy_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      ocnt_q  <= '0;
      omnx_q  <= '0;
      omxx_q  <= '0;
      omny_q  <= '0;
      omxy_q  <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      vld_q   <= vld_d;
      px_x_q  <= px_x_d;
      px_y_q  <= px_y_d;
      cnt_q   <= cnt_d;
      mnx_q   <= mnx_d;
      mxx_q   <= mxx_d;
      mny_q   <= mny_d;
      mxy_q   <= mxy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      ocnt_q  <= ocnt_d;
      omnx_q  <= omnx_d;
      omxx_q  <= omxx_d;
      omny_q  <= omny_d;
      omxy_q  <= omxy_d;
    end
  end

  assign o_Busy  = busy_q;
  assign o_Done  = done_q;
  assign o_Found = found_q;
  assign o_Count = ocnt_q;
  assign o_Min_X = omnx_q;
  assign o_Max_X = omxx_q;
  assign o_Min_Y = omny_q;
  assign o_Max_Y = omxy_q;
endmodule
